// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD picture blitter.
//   - ILI9486 command opcodes emitted ahead of the pixel stream
//   - output pixel format encodings
//   - blitter FSM state type
//   - RGB888 -> RGB565 packing helper
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;   // column address set
    localparam logic [7:0] CMD_PASET = 8'h2B;   // page (row) address set
    localparam logic [7:0] CMD_RAMWR = 8'h2C;   // memory write

    localparam int FMT_RGB888 = 0;
    localparam int FMT_RGB565 = 1;

    // Index of the last word in the 11-word window/command preamble.
    localparam logic [3:0] CMD_LAST_IDX = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        PIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Packed {r,g,b} 8:8:8 -> {r[7:3], g[7:2], b[7:3]}.
    function automatic logic [15:0] rgb565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

endpackage

// File: rtl/lcd_picture_blit_if.sv
// Output word stream from the blitter towards the LCD bus writer.
//   out_valid : word valid (master)
//   out_ready : downstream accept (slave)
//   out_dc    : 0 = command, 1 = data/parameter (master)
//   out_data  : output word, PIX_W bits (master)
interface lcd_picture_blit_if #(
    parameter int PIX_W = 24
);
    logic             out_valid;
    logic             out_ready;
    logic             out_dc;
    logic [PIX_W-1:0] out_data;

    modport master (output out_valid, output out_dc, output out_data, input out_ready);
    modport slave  (input out_valid, input out_dc, input out_data, output out_ready);
endinterface

// File: rtl/lcd_pix_fifo.sv
// Small show-ahead skid FIFO for returning pixels.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers/count)
//   push/wr_data : write request and data
//   pop          : read request; rd_data always shows the head entry
//   full, empty, count : occupancy status
// The head must be visible combinationally so the output word stays stable
// under backpressure without an extra register stage, so storage is read
// asynchronously (a handful of entries, maps to distributed RAM).
module lcd_pix_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // A push into a full FIFO is fine when the same cycle pops.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/lcd_picture_blit.sv
// LCD picture blitter for the ILI9486 path.
// Emits CASET/PASET window words and RAMWR, then streams a win_w x win_h
// rectangle of pixels read row-major from frame RAM starting at base_addr.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : one-cycle launch (ignored while a transfer runs)
//   x, y, win_w, win_h : window origin and size
//   base_addr          : RAM address of the first pixel
//   busy, done         : transfer in progress / one-cycle completion pulse
//   ram_addr, ram_rd_en, ram_data : RAM read port, data RAM_LAT cycles later
//   ob                 : valid/ready output word stream (dc + data)
module lcd_picture_blit
    import lcd_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int COORD_W    = 16,
    parameter int PIX_W      = 24,
    parameter int RAM_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_FMT    = FMT_RGB888
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] win_w,
    input  logic [COORD_W-1:0] win_h,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_rd_en,
    input  logic [PIX_W-1:0]   ram_data,
    lcd_picture_blit_if.master ob
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

    state_t             state_reg, state_next;
    logic [COORD_W-1:0] xs_reg, ys_reg, xe_reg, ye_reg, w_reg, h_reg;
    logic [COORD_W-1:0] rd_col_reg, rd_row_reg, pop_col_reg, pop_row_reg;
    logic               rd_all_reg;
    logic [3:0]         cmd_idx_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [CNT_W-1:0]   in_flight_reg;

    logic               rd_issue, capture, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [PIX_W-1:0]   fifo_wr_data, fifo_rd_data;
    logic [7:0]         cmd_byte;
    logic               cmd_dc;
    logic               pop_last;
    logic [15:0]        xs16, xe16, ys16, ye16;

    assign xs16 = 16'(xs_reg);
    assign xe16 = 16'(xe_reg);
    assign ys16 = 16'(ys_reg);
    assign ye16 = 16'(ye_reg);

    // Outstanding reads plus buffered pixels never exceed the FIFO depth,
    // so every returning word has a guaranteed slot.
    assign rd_issue = (state_reg == PIX) && !rd_all_reg && !fifo_full &&
                      (({1'b0, in_flight_reg} + {1'b0, fifo_count}) < CREDITS);
    assign ram_rd_en = rd_issue;
    assign ram_addr  = addr_reg;

    assign pop_last = (pop_col_reg == w_reg - COORD_W'(1)) &&
                      (pop_row_reg == h_reg - COORD_W'(1));

    // Read-tag pipe: one stage per cycle of RAM latency; the last stage
    // marks the cycle in which ram_data belongs to an issued read.
    for (genvar gi = 0; gi < RAM_LAT; gi++) begin : g_lat
        logic tag_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tag_reg <= 1'b0;
                else        tag_reg <= rd_issue;
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tag_reg <= 1'b0;
                else        tag_reg <= g_lat[gi-1].tag_reg;
            end
        end
    end
    assign capture = g_lat[RAM_LAT-1].tag_reg;

    if (OUT_FMT == FMT_RGB565) begin : g_565
        assign fifo_wr_data = PIX_W'(rgb565(ram_data));
    end else begin : g_888
        assign fifo_wr_data = ram_data;
    end

    lcd_pix_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (capture),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        cmd_byte = CMD_RAMWR;
        cmd_dc   = 1'b1;
        case (cmd_idx_reg)
            4'd0:    begin cmd_byte = CMD_CASET; cmd_dc = 1'b0; end
            4'd1:    cmd_byte = xs16[15:8];
            4'd2:    cmd_byte = xs16[7:0];
            4'd3:    cmd_byte = xe16[15:8];
            4'd4:    cmd_byte = xe16[7:0];
            4'd5:    begin cmd_byte = CMD_PASET; cmd_dc = 1'b0; end
            4'd6:    cmd_byte = ys16[15:8];
            4'd7:    cmd_byte = ys16[7:0];
            4'd8:    cmd_byte = ye16[15:8];
            4'd9:    cmd_byte = ye16[7:0];
            default: begin cmd_byte = CMD_RAMWR; cmd_dc = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        busy         = 1'b0;
        done         = 1'b0;
        ob.out_valid = 1'b0;
        ob.out_dc    = 1'b0;
        ob.out_data  = '0;
        fifo_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (win_w == '0 || win_h == '0) ? DONE : CMD;
                end
            end
            CMD: begin
                busy         = 1'b1;
                ob.out_valid = 1'b1;
                ob.out_dc    = cmd_dc;
                ob.out_data  = PIX_W'(cmd_byte);
                if (ob.out_ready && cmd_idx_reg == CMD_LAST_IDX) state_next = PIX;
            end
            PIX: begin
                busy         = 1'b1;
                ob.out_valid = !fifo_empty;
                ob.out_dc    = !fifo_empty;
                ob.out_data  = fifo_empty ? '0 : fifo_rd_data;
                fifo_pop     = ob.out_ready && !fifo_empty;
                if (fifo_pop && pop_last) state_next = DONE;
            end
            default: begin
                done       = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs_reg <= '0; ys_reg <= '0; xe_reg <= '0; ye_reg <= '0;
            w_reg  <= '0; h_reg  <= '0;
            rd_col_reg  <= '0; rd_row_reg  <= '0; rd_all_reg <= 1'b0;
            pop_col_reg <= '0; pop_row_reg <= '0;
            cmd_idx_reg <= '0;
            addr_reg    <= '0;
            in_flight_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                xs_reg <= x;
                ys_reg <= y;
                xe_reg <= x + win_w - COORD_W'(1);
                ye_reg <= y + win_h - COORD_W'(1);
                w_reg  <= win_w;
                h_reg  <= win_h;
                addr_reg    <= base_addr;
                rd_col_reg  <= '0;
                rd_row_reg  <= '0;
                rd_all_reg  <= 1'b0;
                pop_col_reg <= '0;
                pop_row_reg <= '0;
                cmd_idx_reg <= '0;
            end
            if (state_reg == CMD && ob.out_ready) begin
                cmd_idx_reg <= cmd_idx_reg + 4'd1;
            end
            // Row-major linear index is contiguous, so the address simply
            // increments; row/col counters only detect the final read.
            if (rd_issue) begin
                addr_reg <= addr_reg + ADDR_W'(1);
                if (rd_col_reg == w_reg - COORD_W'(1)) begin
                    rd_col_reg <= '0;
                    if (rd_row_reg == h_reg - COORD_W'(1)) rd_all_reg <= 1'b1;
                    else rd_row_reg <= rd_row_reg + COORD_W'(1);
                end else begin
                    rd_col_reg <= rd_col_reg + COORD_W'(1);
                end
            end
            if (fifo_pop) begin
                if (pop_col_reg == w_reg - COORD_W'(1)) begin
                    pop_col_reg <= '0;
                    pop_row_reg <= pop_row_reg + COORD_W'(1);
                end else begin
                    pop_col_reg <= pop_col_reg + COORD_W'(1);
                end
            end
            case ({rd_issue, capture})
                2'b10:   in_flight_reg <= in_flight_reg + CNT_W'(1);
                2'b01:   in_flight_reg <= in_flight_reg - CNT_W'(1);
                default: in_flight_reg <= in_flight_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_picture_blit.sv
// Bench for lcd_picture_blit: two instances share stimulus, one with
// RAM_LAT=3 / RGB888 and one with RAM_LAT=1 / RGB565. Expected words and
// read addresses are queued when a transfer is launched; per-instance
// monitors pop and compare whenever the DUT presents a word or a read.
`timescale 1ns/1ps
module tb_lcd_picture_blit;
    localparam int ADDR_W = 18;
    localparam int COORD_W = 16;
    localparam int PIX_W = 24;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic [15:0] x, y, win_w, win_h;
    logic [17:0] base_addr;
    bit          rand_ready;

    logic [24:0] exp_q [2][$];
    logic [17:0] addr_q[2][$];
    int          cmd_left[2];
    int          reads_n[2];
    int          pops_n[2];
    bit          pending[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Frame RAM contents: a scrambled function of the address, with one
    // known colour planted at 0x200.
    function automatic logic [23:0] ram_pix(input logic [17:0] a);
        logic [31:0] t;
        if (a == 18'h00200) return 24'hFF8040;
        t = {14'h0, a} * 32'd2654435761 + 32'd12345;
        return t[31:8];
    endfunction

    function automatic logic [15:0] to565(input logic [23:0] p);
        logic [7:0] r, g, b;
        r = p[23:16]; g = p[15:8]; b = p[7:0];
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int LAT = (gi == 0) ? 3 : 1;
        localparam int FMT = gi;

        logic        busy, done, ram_rd_en;
        logic [17:0] ram_addr;
        logic [23:0] ram_data;
        logic [23:0] dpipe[LAT];
        logic [46:0] outs;

        lcd_picture_blit_if #(.PIX_W(PIX_W)) ob ();

        lcd_picture_blit #(
            .ADDR_W(ADDR_W), .COORD_W(COORD_W), .PIX_W(PIX_W),
            .RAM_LAT(LAT), .FIFO_DEPTH(DEPTH), .OUT_FMT(FMT)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .x         (x),
            .y         (y),
            .win_w     (win_w),
            .win_h     (win_h),
            .base_addr (base_addr),
            .busy      (busy),
            .done      (done),
            .ram_addr  (ram_addr),
            .ram_rd_en (ram_rd_en),
            .ram_data  (ram_data),
            .ob        (ob)
        );

        assign outs = {busy, done, ram_rd_en, ram_addr, ob.out_valid, ob.out_dc, ob.out_data};

        // RAM model with LAT-cycle read latency.
        assign ram_data = dpipe[LAT-1];
        always @(posedge clk) begin
            dpipe[0] <= ram_rd_en ? ram_pix(ram_addr) : 24'h0;
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end

        initial begin
            ob.out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                ob.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end

        initial begin : mon
            bit          stall_v;
            logic [24:0] stall_w, got, want;
            logic [17:0] want_a;
            stall_v = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    stall_v = 1'b0;
                end else begin
                    got = {ob.out_dc, ob.out_data};
                    if (stall_v)
                        chk(ob.out_valid && got == stall_w, $sformatf("stall_hold[%0d]", gi),
                            {ob.out_valid, got}, {1'b1, stall_w});
                    if (ram_rd_en) begin
                        chk(cmd_left[gi] == 0, $sformatf("early_read[%0d]", gi), cmd_left[gi], 0);
                        chk(reads_n[gi] - pops_n[gi] + 1 <= DEPTH, $sformatf("credit[%0d]", gi),
                            reads_n[gi] - pops_n[gi] + 1, DEPTH);
                        if (addr_q[gi].size() == 0) begin
                            chk(1'b0, $sformatf("extra_read[%0d]", gi), ram_addr, 0);
                        end else begin
                            want_a = addr_q[gi].pop_front();
                            chk(ram_addr == want_a, $sformatf("rd_addr[%0d]", gi), ram_addr, want_a);
                        end
                        reads_n[gi]++;
                    end
                    if (ob.out_valid && ob.out_ready) begin
                        if (exp_q[gi].size() == 0) begin
                            chk(1'b0, $sformatf("extra_word[%0d]", gi), got, 0);
                        end else begin
                            want = exp_q[gi].pop_front();
                            chk(got == want, $sformatf("%s[%0d]", (cmd_left[gi] > 0) ? "cmd_word" : "pixel", gi),
                                got, want);
                            if (cmd_left[gi] > 0) cmd_left[gi]--;
                            else pops_n[gi]++;
                        end
                    end
                    if (done) begin
                        chk(pending[gi] && exp_q[gi].size() == 0 && addr_q[gi].size() == 0 && !busy,
                            $sformatf("done[%0d]", gi),
                            {pending[gi], 16'(exp_q[gi].size()), busy}, {1'b1, 16'h0, 1'b0});
                        pending[gi] = 1'b0;
                    end
                    stall_v = ob.out_valid && !ob.out_ready;
                    stall_w = got;
                end
            end
        end
    end

    task automatic launch(input logic [15:0] xi, yi, wi, hi, input logic [17:0] bi);
        logic [15:0] xe, ye;
        logic [17:0] a;
        logic [23:0] p;
        xe = xi + wi - 16'd1;
        ye = yi + hi - 16'd1;
        for (int k = 0; k < 2; k++) begin
            if (wi != 0 && hi != 0) begin
                exp_q[k].push_back({1'b0, 24'h00002A});
                exp_q[k].push_back({1'b1, 16'h0, xi[15:8]});
                exp_q[k].push_back({1'b1, 16'h0, xi[7:0]});
                exp_q[k].push_back({1'b1, 16'h0, xe[15:8]});
                exp_q[k].push_back({1'b1, 16'h0, xe[7:0]});
                exp_q[k].push_back({1'b0, 24'h00002B});
                exp_q[k].push_back({1'b1, 16'h0, yi[15:8]});
                exp_q[k].push_back({1'b1, 16'h0, yi[7:0]});
                exp_q[k].push_back({1'b1, 16'h0, ye[15:8]});
                exp_q[k].push_back({1'b1, 16'h0, ye[7:0]});
                exp_q[k].push_back({1'b0, 24'h00002C});
                cmd_left[k] = 11;
                for (int r = 0; r < int'(hi); r++) begin
                    for (int c = 0; c < int'(wi); c++) begin
                        a = bi + 18'(r * int'(wi) + c);
                        p = ram_pix(a);
                        addr_q[k].push_back(a);
                        exp_q[k].push_back({1'b1, (k == 1) ? {8'h0, to565(p)} : p});
                    end
                end
            end
            pending[k] = 1'b1;
        end
        x = xi; y = yi; win_w = wi; win_h = hi; base_addr = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (wi != 0 && hi != 0) begin
            chk(g_cfg[0].busy == 1'b1, "busy_rise[0]", g_cfg[0].busy, 1);
            chk(g_cfg[1].busy == 1'b1, "busy_rise[1]", g_cfg[1].busy, 1);
        end else begin
            chk(g_cfg[0].done == 1'b1, "zero_done[0]", g_cfg[0].done, 1);
            chk(g_cfg[1].done == 1'b1, "zero_done[1]", g_cfg[1].done, 1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while ((pending[0] || pending[1]) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk(!pending[0] && !pending[1], {tag, "_timeout"}, {pending[0], pending[1]}, 0);
        chk(exp_q[0].size() == 0 && exp_q[1].size() == 0, {tag, "_words_left"},
            exp_q[0].size() + exp_q[1].size(), 0);
        chk(addr_q[0].size() == 0 && addr_q[1].size() == 0, {tag, "_reads_left"},
            addr_q[0].size() + addr_q[1].size(), 0);
        flush();
    endtask

    task automatic flush();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            addr_q[k].delete();
            pending[k]  = 1'b0;
            cmd_left[k] = 0;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(g_cfg[0].outs == '0, {tag, "[0]"}, g_cfg[0].outs, 0);
        chk(g_cfg[1].outs == '0, {tag, "[1]"}, g_cfg[1].outs, 0);
    endtask

    initial begin
        int p0, cyc;
        rst_n = 1'b0; start = 1'b0; rand_ready = 1'b0;
        x = '0; y = '0; win_w = '0; win_h = '0; base_addr = '0;
        for (int k = 0; k < 2; k++) begin
            reads_n[k] = 0; pops_n[k] = 0; cmd_left[k] = 0; pending[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic transfer
        launch(16'h0010, 16'h0020, 16'd2, 16'd2, 18'h00100);
        wait_idle("basic");

        // Format check on a known colour, then address wrap
        launch(16'h0001, 16'h0002, 16'd1, 16'd1, 18'h00200);
        wait_idle("fmt");
        launch(16'h0005, 16'h0006, 16'd4, 16'd1, 18'h3FFFE);
        wait_idle("wrap");

        // Zero-size window
        launch(16'h0003, 16'h0004, 16'd0, 16'd9, 18'h01000);
        wait_idle("zero");

        // Start pulsed mid-transfer must be ignored
        launch(16'h00F0, 16'h0140, 16'd3, 16'd3, 18'h02000);
        repeat (3) @(posedge clk);
        #1;
        x = 16'h1111; y = 16'h2222; win_w = 16'd5; win_h = 16'd5; base_addr = 18'h0ABCD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("ignored_start");

        // Backpressure and random windows
        rand_ready = 1'b1;
        launch(16'($urandom), 16'($urandom), 16'd7, 16'd5, 18'($urandom));
        wait_idle("backpressure");
        for (int t = 0; t < 6; t++) begin
            launch(16'($urandom), 16'($urandom), 16'($urandom_range(1, 9)),
                   16'($urandom_range(1, 5)), 18'($urandom));
            wait_idle($sformatf("random%0d", t));
        end

        // Reset during the pixel phase
        rand_ready = 1'b0;
        p0 = pops_n[0];
        launch(16'h0003, 16'h0004, 16'd8, 16'd4, 18'h01234);
        cyc = 0;
        while (pops_n[0] - p0 < 3 && cyc < 500) begin
            @(posedge clk);
            cyc++;
        end
        chk(pops_n[0] - p0 >= 3, "reset_wait_pixels", pops_n[0] - p0, 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        flush();
        for (int k = 0; k < 2; k++) begin
            reads_n[k] = 0;
            pops_n[k]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        launch(16'h0100, 16'h0080, 16'd5, 16'd3, 18'h03F00);
        wait_idle("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
